alu: RTL and testbench

ALU -- requirements
Module: ALU

---
 rtl/alu.sv | 94 +++++++++
 tb/tb_alu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 8-bit ALU: sixteen operations selected by sel, with zero and
// negative flags that always describe the result currently held.
module alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_A,
    input  logic [7:0] in_B,
    input  logic [3:0] sel,
    output logic [7:0] result,
    output logic       Z,
    output logic       N
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOT   = 4'b0101,
        OP_SHL   = 4'b0110,
        OP_SHR   = 4'b0111,
        OP_PASSB = 4'b1000,
        OP_PASSA = 4'b1001,
        OP_INC   = 4'b1010,
        OP_DEC   = 4'b1011,
        OP_ASR   = 4'b1100,
        OP_ROL   = 4'b1101,
        OP_ROR   = 4'b1110,
        OP_CLR   = 4'b1111
    } op_e;

    logic [7:0] and_bits;
    logic [7:0] or_bits;
    logic [7:0] xor_bits;
    logic [7:0] not_bits;

    logic [7:0] result_reg;
    logic [7:0] result_next;
    logic       z_reg;
    logic       n_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bitwise
            assign and_bits[gi] = in_A[gi] & in_B[gi];
            assign or_bits[gi]  = in_A[gi] | in_B[gi];
            assign xor_bits[gi] = in_A[gi] ^ in_B[gi];
            assign not_bits[gi] = ~in_A[gi];
        end
    endgenerate

    // Carries and borrows fall off the top: 8-bit truncation is the intended wrap.
    always_comb begin
        result_next = 8'h00;
        case (op_e'(sel))
            OP_ADD:   result_next = in_A + in_B;
            OP_SUB:   result_next = in_A - in_B;
            OP_AND:   result_next = and_bits;
            OP_OR:    result_next = or_bits;
            OP_XOR:   result_next = xor_bits;
            OP_NOT:   result_next = not_bits;
            OP_SHL:   result_next = {in_A[6:0], 1'b0};
            OP_SHR:   result_next = {1'b0, in_A[7:1]};
            OP_PASSB: result_next = in_B;
            OP_PASSA: result_next = in_A;
            OP_INC:   result_next = in_A + 8'd1;
            OP_DEC:   result_next = in_A - 8'd1;
            OP_ASR:   result_next = {in_A[7], in_A[7:1]};
            OP_ROL:   result_next = {in_A[6:0], in_A[7]};
            OP_ROR:   result_next = {in_A[0], in_A[7:1]};
            OP_CLR:   result_next = 8'h00;
            default:  result_next = 8'h00;
        endcase
    end

    // Flags are derived from result_next so they land in the same cycle as the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= 8'h00;
            z_reg      <= 1'b1;
            n_reg      <= 1'b0;
        end else begin
            result_reg <= result_next;
            z_reg      <= (result_next == 8'h00);
            n_reg      <= result_next[7];
        end
    end

    assign result = result_reg;
    assign Z      = z_reg;
    assign N      = n_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand-written latency and
// reset sequences, then random operations against an arithmetic reference.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [7:0] in_A;
    logic [7:0] in_B;
    logic [3:0] sel;
    logic [7:0] result;
    logic       Z;
    logic       N;

    int checks;
    int errors;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .in_A   (in_A),
        .in_B   (in_B),
        .sel    (sel),
        .result (result),
        .Z      (Z),
        .N      (N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       rst;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] res;
        logic       z;
        logic       n;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [7:0] a, logic [7:0] b, logic [3:0] s,
                                logic [7:0] res, logic z, logic n);
        vec_t v;
        v.rst = r; v.a = a; v.b = b; v.sel = s; v.res = res; v.z = z; v.n = n;
        return v;
    endfunction

    // Reference written from the operation definitions in plain integer arithmetic.
    function automatic int ref_op(int a, int b, int s);
        case (s)
            0:  return (a + b) % 256;
            1:  return (a - b + 256) % 256;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return 255 - a;
            6:  return (a * 2) % 256;
            7:  return a / 2;
            8:  return b;
            9:  return a;
            10: return (a + 1) % 256;
            11: return (a + 255) % 256;
            12: return (a / 2) + ((a >= 128) ? 128 : 0);
            13: return ((a * 2) % 256) + a / 128;
            14: return a / 2 + (a % 2) * 128;
            default: return 0;
        endcase
    endfunction

    task automatic check(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic check_all(string tag, logic [7:0] er, logic ez, logic en);
        check({tag, " result"}, int'(result), int'(er));
        check({tag, " Z"}, int'(Z), int'(ez));
        check({tag, " N"}, int'(N), int'(en));
    endtask

    task automatic apply(logic r, logic [7:0] a, logic [7:0] b, logic [3:0] s);
        @(negedge clk);
        rst = r; in_A = a; in_B = b; sel = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; in_A = 8'h00; in_B = 8'h00; sel = 4'h0;

        vecs.push_back(mk(1, 8'h0C, 8'h09, 4'h0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 8'h0C, 8'h09, 4'h0, 8'h15, 0, 0));
        vecs.push_back(mk(0, 8'h0C, 8'h09, 4'h1, 8'h03, 0, 0));
        vecs.push_back(mk(0, 8'h0C, 8'h09, 4'h2, 8'h08, 0, 0));
        vecs.push_back(mk(0, 8'h0C, 8'h09, 4'h3, 8'h0D, 0, 0));
        vecs.push_back(mk(0, 8'h0C, 8'h09, 4'h4, 8'h05, 0, 0));
        vecs.push_back(mk(0, 8'h0C, 8'h09, 4'h5, 8'hF3, 0, 1));
        vecs.push_back(mk(0, 8'h0C, 8'h09, 4'h6, 8'h18, 0, 0));
        vecs.push_back(mk(0, 8'h0C, 8'h09, 4'h7, 8'h06, 0, 0));
        vecs.push_back(mk(0, 8'h0C, 8'h09, 4'h8, 8'h09, 0, 0));
        vecs.push_back(mk(0, 8'hFF, 8'h01, 4'h0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'h01, 4'h1, 8'hFF, 0, 1));
        vecs.push_back(mk(0, 8'h81, 8'h00, 4'h6, 8'h02, 0, 0));
        vecs.push_back(mk(0, 8'h81, 8'h00, 4'h7, 8'h40, 0, 0));
        vecs.push_back(mk(0, 8'h81, 8'h00, 4'hC, 8'hC0, 0, 1));
        vecs.push_back(mk(0, 8'h81, 8'h00, 4'hD, 8'h03, 0, 0));
        vecs.push_back(mk(0, 8'h81, 8'h00, 4'hE, 8'hC0, 0, 1));
        vecs.push_back(mk(0, 8'h81, 8'h3C, 4'h9, 8'h81, 0, 1));
        vecs.push_back(mk(0, 8'hFF, 8'h00, 4'hA, 8'h00, 1, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 4'hB, 8'hFF, 0, 1));
        vecs.push_back(mk(0, 8'h40, 8'h00, 4'hC, 8'h20, 0, 0));
        vecs.push_back(mk(0, 8'hFF, 8'hFF, 4'hF, 8'h00, 1, 0));
        vecs.push_back(mk(1, 8'hFF, 8'hFF, 4'h5, 8'h00, 1, 0));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].sel);
            check_all($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].n);
        end

        // Latency: inputs changed while clk is low or just after an edge must not
        // disturb the registered outputs until the next rising edge.
        apply(0, 8'h0C, 8'h09, 4'h0);
        check_all("lat_add", 8'h15, 0, 0);
        in_A = 8'h00; in_B = 8'h00; sel = 4'hF;
        #2;
        check_all("lat_hold_post_edge", 8'h15, 0, 0);
        @(negedge clk);
        in_A = 8'h0C; in_B = 8'h09; sel = 4'h1;
        #2;
        check_all("lat_hold_clk_low", 8'h15, 0, 0);
        @(posedge clk);
        #1;
        check_all("lat_new_op", 8'h03, 0, 0);

        // Reset in the middle of an ADD sequence.
        apply(0, 8'h0C, 8'h09, 4'h0);
        check_all("rstmid_before", 8'h15, 0, 0);
        apply(1, 8'h0C, 8'h09, 4'h0);
        check_all("rstmid_at", 8'h00, 1, 0);
        apply(0, 8'h0C, 8'h09, 4'h0);
        check_all("rstmid_resume", 8'h15, 0, 0);

        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic [7:0] a;
            logic [7:0] b;
            logic [3:0] s;
            int         exp_r;
            r = ($urandom_range(0, 15) == 0);
            a = 8'($urandom);
            b = 8'($urandom);
            s = 4'($urandom);
            exp_r = r ? 0 : ref_op(int'(a), int'(b), int'(s));
            apply(r, a, b, s);
            check_all($sformatf("rand%0d sel=%0h a=%0h b=%0h rst=%0d", i, s, a, b, r),
                      8'(exp_r), (exp_r == 0), (exp_r >= 128));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
